jk_bank_driver: RTL
===================

# jk_bank_driver

Command-side controller for the JK flip-flop register bank. It accepts a target word over a valid/ready handshake and derives per-bit J/K excitation from the bank's current Q. It pulses the excitation for one clock, waits for the bank to settle, then checks the Q feedback and retries on mismatch. It sits between a register-write initiator and the JK bank, and drives the bank's J and K inputs.

## Interface
- `WIDTH`, 32: bank word width.
- `CHECK_LAT`, 1: SETTLE cycles between DRIVE and CHECK (≥1).
- `MAX_RETRY`, 2: extra DRIVE attempts after a failed CHECK (0 = single attempt).

Ports:
- `clk`  in  1  single clock, rising edge. Reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  1  target word offered.
- `req_ready`  out  1  = (state==IDLE) && rst_n.
- `req_target`  in  WIDTH  desired bank value; sampled only at accept.
- `fb_q`  in  WIDTH  bank Q feedback.
- `drv_j`  out  WIDTH  J inputs to bank (registered).
- `drv_k`  out  WIDTH  K inputs to bank (registered).
- `busy`  out  1  high in DRIVE/SETTLE/CHECK.
- `done`  out  1  one-cycle pulse: bank matched target.
- `err`  out  1  one-cycle pulse: retries exhausted.
- `fail_mask`  out  WIDTH  target ^ fb_q at the final CHECK; held until next accept, cleared at accept.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK.
- **IDLE**
  - On accept (`req_valid && req_ready`), latch the target and `fb_q`, clear the retry count, and go to DRIVE.
- **DRIVE** (1 cycle)
  - `drv_j = tgt & ~q`, `drv_k = ~tgt & q`. Only bits that change are driven.
  - J=K=1 (toggle) is never issued.
  - If tgt==q, both are 0 and the full sequence still runs.
- **SETTLE** (`CHECK_LAT` cycles)
  - `drv_j = drv_k = 0` (hold).
- **CHECK** (1 cycle): compare `fb_q` with tgt.
  - Equal: go to IDLE and pulse `done` in the next cycle.
  - Unequal and retries < `MAX_RETRY`: latch `fb_q` as q, increment retries, go to DRIVE.
  - Unequal and retries exhausted: go to IDLE and pulse `err` in the next cycle.
  - `fail_mask` updates at every CHECK.
- `drv_j` and `drv_k` are 0 in every state except DRIVE.
- `req_valid` is ignored while busy. The initiator holds it until accepted.
- `done` and `err` are never high together.

## Timing
- Reset values: state IDLE, `drv_j`/`drv_k`/`fail_mask` 0, `busy`/`done`/`err` 0, retries 0. `req_ready` is 1 from the first cycle with `rst_n` high.
- With accept at cycle 0:
  - DRIVE at c1.
  - SETTLE at c2..c(1+CHECK_LAT).
  - CHECK at c(2+CHECK_LAT).
  - `done`/`err` at c(3+CHECK_LAT), coincident with IDLE and `req_ready`=1.
- A new request can be accepted in the `done`/`err` cycle.
- Each failed attempt adds CHECK_LAT+2 cycles.
- Reset mid-operation: all outputs reach their reset values at the next edge, and no `done`/`err` is issued.

## Structure
- Package `jk_drv_pkg`:
  - state enum `jk_drv_state_t` (IDLE, DRIVE, SETTLE, CHECK);
  - excitation constants for SET (J1K0), CLR (J0K1) and HOLD (J0K0).
- Sub-module `jk_excite`: combinational per-bit excitation (tgt, q → j, k), parameterized by WIDTH.
- Top module: FSM, SETTLE counter (width $clog2(CHECK_LAT+1)), retry counter, output registers.

## Test plan
Bench uses WIDTH=4, CHECK_LAT=1, MAX_RETRY=2 and a behavioral JK bank model driving `fb_q`.
- Reset: `rst_n` low 2 cycles with `req_valid`=1 → `drv_j`=`drv_k`=0, `busy`=`done`=`err`=0, no accept; `req_ready`=1 after release.
- Bank 0000, target 0101 accepted at c0 → c1 `drv_j`=0101, `drv_k`=0000; c4 `done`=1, `fail_mask`=0000.
- Bank 1100, target 0110 → c1 `drv_j`=0010, `drv_k`=1000; c4 `done`=1, bank 0110.
- Model bit0 stuck at 0, target 0001 → `drv_j`=0001 at c1, c4, c7; `err`=1 at c10, no `done`; `fail_mask`=0001.
- `rst_n` low during c1 (DRIVE) → c2 `drv_j`=`drv_k`=0, `busy`=0, no `done`/`err` afterwards.
- Second request with target 1010 held from c1 during a busy op → not accepted until c4 (`done` cycle); its DRIVE at c5, its `done` at c8.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// =============================================================================
// jk_drv_pkg : shared state type and JK excitation encodings for the bank driver
// Revision   : 1.0
// =============================================================================
`default_nettype none

package jk_drv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SETTLE = 2'd2,
      CHECK  = 2'd3
   } jk_drv_state_t;

   // Excitation pairs packed as {J, K}; toggle (2'b11) is deliberately absent.
   localparam logic [1:0] c_exc_set  = 2'b10;
   localparam logic [1:0] c_exc_clr  = 2'b01;
   localparam logic [1:0] c_exc_hold = 2'b00;

   function automatic logic [1:0] jk_exc_bit(input logic tgt, input logic q);
      logic [1:0] r;
      r = c_exc_hold;
      if (tgt && !q) begin
         r = c_exc_set;
      end else if (!tgt && q) begin
         r = c_exc_clr;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jk_excite.sv
// =============================================================================
// jk_excite : per-bit J/K excitation that moves the bank from q to tgt
// Revision  : 1.0
// =============================================================================
`default_nettype none

module jk_excite
   import jk_drv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] tgt_i,
   input  logic [WIDTH-1:0] q_i,
   output logic [WIDTH-1:0] j_o,
   output logic [WIDTH-1:0] k_o
);

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [1:0] w_jk;
      assign w_jk    = jk_exc_bit(tgt_i[gi], q_i[gi]);
      assign j_o[gi] = w_jk[1];
      assign k_o[gi] = w_jk[0];
   end

endmodule

`default_nettype wire

// File: rtl/jk_bank_driver.sv
// =============================================================================
// jk_bank_driver : drives a JK register bank to a requested word, verifies the
//                  Q feedback after settling and retries a bounded number of times
// Revision       : 1.0
// =============================================================================
`default_nettype none

module jk_bank_driver
   import jk_drv_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int CHECK_LAT = 1,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_target,
   input  logic [WIDTH-1:0] fb_q,
   output logic [WIDTH-1:0] drv_j,
   output logic [WIDTH-1:0] drv_k,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] fail_mask
);

   localparam int c_settle_w = $clog2(CHECK_LAT + 1);
   localparam int c_retry_w  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(CHECK_LAT - 1);
   localparam logic [c_retry_w-1:0]  c_retry_max   = c_retry_w'(MAX_RETRY);

   jk_drv_state_t           state_q, state_d;
   logic [WIDTH-1:0]        tgt_q, tgt_d;
   logic [c_settle_w-1:0]   settle_q, settle_d;
   logic [c_retry_w-1:0]    retry_q, retry_d;
   logic [WIDTH-1:0]        drv_j_q, drv_j_d;
   logic [WIDTH-1:0]        drv_k_q, drv_k_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [WIDTH-1:0]        fail_mask_q, fail_mask_d;

   logic                    w_accept;
   logic                    w_match;
   logic [WIDTH-1:0]        w_exc_tgt;
   logic [WIDTH-1:0]        w_exc_j;
   logic [WIDTH-1:0]        w_exc_k;

   assign req_ready = (state_q == IDLE) && rst_n;
   assign w_accept  = req_valid && req_ready;
   assign w_match   = (fb_q == tgt_q);

   // Excitation is computed in the cycle before DRIVE so the J/K registers
   // present it exactly during DRIVE; q is always the live feedback.
   assign w_exc_tgt = (state_q == IDLE) ? req_target : tgt_q;

   jk_excite #(
      .WIDTH (WIDTH)
   ) u_excite (
      .tgt_i (w_exc_tgt),
      .q_i   (fb_q),
      .j_o   (w_exc_j),
      .k_o   (w_exc_k)
   );

   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      settle_d    = settle_q;
      retry_d     = retry_q;
      drv_j_d     = '0;
      drv_k_d     = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      fail_mask_d = fail_mask_q;

      case (state_q)
         IDLE: begin
            if (w_accept) begin
               tgt_d       = req_target;
               retry_d     = '0;
               fail_mask_d = '0;
               drv_j_d     = w_exc_j;
               drv_k_d     = w_exc_k;
               state_d     = DRIVE;
            end
         end
         DRIVE: begin
            settle_d = '0;
            state_d  = SETTLE;
         end
         SETTLE: begin
            if (settle_q == c_settle_last) begin
               state_d = CHECK;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         CHECK: begin
            fail_mask_d = tgt_q ^ fb_q;
            if (w_match) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (retry_q < c_retry_max) begin
               retry_d = retry_q + 1'b1;
               drv_j_d = w_exc_j;
               drv_k_d = w_exc_k;
               state_d = DRIVE;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tgt_q       <= '0;
         settle_q    <= '0;
         retry_q     <= '0;
         drv_j_q     <= '0;
         drv_k_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         fail_mask_q <= '0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         settle_q    <= settle_d;
         retry_q     <= retry_d;
         drv_j_q     <= drv_j_d;
         drv_k_q     <= drv_k_d;
         done_q      <= done_d;
         err_q       <= err_d;
         fail_mask_q <= fail_mask_d;
      end
   end

   assign drv_j     = drv_j_q;
   assign drv_k     = drv_k_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign fail_mask = fail_mask_q;

endmodule

`default_nettype wire
